// File: rtl/dispatch_ctrl.sv
// Decode-stage sequencer: instruction FIFO feeding a decoder, one-hot valid/ready dispatch to NUM_UNITS units.
// Optional macro DISPATCH_STALL_CNT_EN adds the saturating stall_cycles counter output.
module dispatch_ctrl #(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 4,
  parameter int EXW       = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [31:0]              fetch_inst,
  input  logic [31:0]              fetch_pc,
  output logic [31:0]              dec_inst,
  output logic [31:0]              dec_pc,
  input  logic [EXW-1:0]           dec_ex_unit,
  output logic [NUM_UNITS-1:0]     disp_valid,
  input  logic [NUM_UNITS-1:0]     disp_ready,
  output logic [31:0]              disp_inst,
  output logic [31:0]              disp_pc,
  output logic                     illegal,
`ifdef DISPATCH_STALL_CNT_EN
  output logic [31:0]              stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [EXW:0] MAX_UNIT = (EXW+1)'(NUM_UNITS);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [31:0]           inst_mem_q [DEPTH];
  logic [31:0]           pc_mem_q   [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NUM_UNITS-1:0]  sel_q, sel_d;
  logic [31:0]           out_inst_q, out_inst_d;
  logic [31:0]           out_pc_q, out_pc_d;
  logic                  illegal_q, illegal_d;

  logic fifo_empty, head_legal, holding, accept, take, load, drop, push;

  // Handshake and FIFO control decoded from the current state and decoder result
  always_comb begin
    fifo_empty  = (count_q == '0);
    fetch_ready = (count_q < CW'(DEPTH));
    dec_inst    = fifo_empty ? NOP_INST : inst_mem_q[rd_ptr_q];
    dec_pc      = fifo_empty ? 32'h0    : pc_mem_q[rd_ptr_q];
    head_legal  = (dec_ex_unit != '0) && ({1'b0, dec_ex_unit} <= MAX_UNIT);
    holding     = (state_q == S_HOLD);
    accept      = holding && |(sel_q & disp_ready);
    take        = !fifo_empty && (!holding || accept);
    load        = take && head_legal;
    drop        = take && !head_legal;
    push        = fetch_valid && fetch_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_HOLD;
      S_HOLD:  if (accept) state_d = load ? S_HOLD : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Output decode: the held one-hot select is only visible while holding
  always_comb begin
    disp_valid = holding ? sel_q : '0;
    disp_inst  = out_inst_q;
    disp_pc    = out_pc_q;
    illegal    = illegal_q;
    occupancy  = count_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(take);
    count_d    = count_q + CW'(push) - CW'(take);
    sel_d      = sel_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    illegal_d  = drop;
    if (load) begin
      sel_d      = NUM_UNITS'(1) << (dec_ex_unit - 1'b1);
      out_inst_d = dec_inst;
      out_pc_d   = dec_pc;
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      sel_d      = '0;
      out_inst_d = '0;
      out_pc_d   = '0;
      illegal_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      out_inst_q <= '0;
      out_pc_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
      illegal_q  <= illegal_d;
    end
  end

  // Storage needs no reset: entries are only read below a valid count
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem_q[wr_ptr_q] <= fetch_inst;
      pc_mem_q[wr_ptr_q]   <= fetch_pc;
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (holding && !accept && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
